alu_seq: RTL
============

Name: alu_seq

Overview:
Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Single-cycle ops: AND, ORR, ADD, SUB, PASS-B, executed in one registered cycle.
- Iterative ops: MUL (shift-add) and UDIV/UREM (restoring).
- Full NZCV flags; valid/ready handshakes on input and output so the execute stage can stall on long ops.
- Sits in the EX stage of the pipelined core, replacing the combinational ALU.

Parameters:
N, 64, operand/result width (≥4).
CNT_W, $clog2(N)+1, iteration counter width (derived, not overridden).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  in  1  operation request valid
in_ready  out  1  block can accept a request (high only in IDLE)
a  in  N  operand A
b  in  N  operand B
ALUControl  in  4  opcode, sampled with in_valid&&in_ready
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  N  result
zero  out  1  result == 0
flags  out  4  {N,Z,C,V}
div0  out  1  UDIV/UREM with b == 0 (only with ALU_DIV_EN)

Behaviour:
Opcodes:
- 0000 AND
- 0001 ORR
- 0010 ADD
- 0110 SUB
- 0111 PASSB
- 1000 MUL (low N bits of a*b)
- 1001 UDIV
- 1010 UREM
- any other: result = all ones

Reset (reset=0, async):
- State IDLE; in_ready=1; out_valid=0.
- result=0, flags=0, zero=0, div0=0; counter and internal registers 0.
- Reset mid-operation aborts the op with no output.

States:
- IDLE: on accept, a simple or illegal op goes to DONE at the next edge with result registered. MUL goes to MUL. UDIV/UREM go to DIV, unless b==0, which goes straight to DONE.
- MUL: one partial-product step per cycle, exactly N cycles, then DONE.
- DIV: one quotient bit per cycle, exactly N cycles, then DONE.
- DONE: out_valid=1; outputs held stable until out_ready=1, then IDLE.

Latency (accept edge to out_valid): simple ops 1 cycle; MUL and DIV N+1 cycles.

Handshake:
- in_ready = (state==IDLE).
- No new request is accepted while in DONE, even if out_ready is high in the same cycle. Throughput for simple ops is therefore 1 per 2 cycles.

Flags:
- N = result[N-1].
- Z = zero.
- ADD: C = carry out of the N+1-bit sum; V = (a[N-1]==b[N-1]) && (result[N-1]!=a[N-1]).
- SUB: computed as a + ~b + 1. C = no-borrow; V = (a[N-1]!=b[N-1]) && (result[N-1]!=a[N-1]).
- All other ops: C = V = 0.

Division by zero:
- UDIV result = 0; UREM result = a; div0 = 1.
- Latency is 1 cycle.

Boundaries:
- MUL with either operand 0 still takes N cycles.
- Operands are latched at accept; changes to a, b or ALUControl during the op are ignored.
- in_valid while busy is ignored; it is neither queued nor dropped silently. The requester must hold it until in_ready.

Optional Feature:
Macro ALU_DIV_EN.
- Defined: UDIV/UREM, the DIV state and the div0 port all exist.
- Undefined: opcodes 1001/1010 behave as illegal (all ones, 1-cycle latency). The div0 port is absent; instantiators must guard the connection with the same macro.

Decomposition:
Package alu_seq_pkg holds:
- enum alu_op_e with the opcode values listed above.
- enum state_e {IDLE, MUL, DIV, DONE}.
- flag bit-index constants FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0.

Sub-module iter_divider (N-parameterised restoring divider with start/done):
- Instantiated only under ALU_DIV_EN.
- The multiplier stays inline.

Test Plan:
- N=64, ADD a=64'h7FFF_FFFF_FFFF_FFFF b=1 -> 1 cycle later out_valid=1, result=64'h8000_0000_0000_0000, flags=4'b1001 (N,V).
- SUB a=5 b=5 -> result=0, zero=1, flags=4'b0110 (Z,C); illegal opcode 4'b1111 -> result=all ones, flags N=1.
- MUL a=64'd123456789 b=64'd1000 -> out_valid exactly 65 cycles after accept, result=64'd123456789000; in_ready=0 throughout; in_valid pulses during the op are ignored.
- ALU_DIV_EN: UDIV a=100 b=7 -> result=14 after 65 cycles; UREM -> result=2; UDIV b=0 -> result=0, div0=1 after 1 cycle.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> result/flags stable, in_ready=0; release -> IDLE next edge.
- Assert reset=0 at cycle 20 of a MUL -> out_valid=0 and in_ready=1 immediately, result=0; the next ADD 2+3 -> result=5.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and flag bit positions
// shared by alu_seq and iter_divider
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_ORR   = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0110,
    OP_PASSB = 4'b0111,
    OP_MUL   = 4'b1000,
    OP_UDIV  = 4'b1001,
    OP_UREM  = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_e;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/alu_seq_iter_divider.sv
// iter_divider: restoring unsigned divider, one quotient bit per cycle
// done/quotient/remainder reflect the step taken on the coming edge
module iter_divider
  import alu_seq_pkg::*;
#(
  parameter int N = 64,
  localparam int CNT_W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]     quo_q;
  logic [N-1:0]     dvs_q;
  logic [N-1:0]     rem_q;
  logic [N:0]       sh;
  logic [N:0]       diff;
  logic             fits;
  logic [N-1:0]     quo_nx;
  logic [N-1:0]     rem_nx;

  // borrow out of diff means the shifted remainder is below the divisor
  assign sh     = {rem_q, quo_q[N-1]};
  assign diff   = sh - {1'b0, dvs_q};
  assign fits   = !diff[N];
  assign rem_nx = fits ? diff[N-1:0] : sh[N-1:0];
  assign quo_nx = {quo_q[N-2:0], fits};

  assign done      = busy_q && (cnt_q == LAST);
  assign quotient  = quo_nx;
  assign remainder = rem_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
      rem_q  <= '0;
    end else if (busy_q) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle EX-stage ALU with valid/ready handshakes
// UDIV/UREM and the div0 port exist only when ALU_DIV_EN is defined
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int N = 64,
  localparam int CNT_W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero,
`ifdef ALU_DIV_EN
  output logic         div0,
`endif
  output logic [3:0]   flags
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_e           state_q;
  state_e           state_d;
  alu_op_e          op;
  logic             accept;
  logic             is_div;
  logic [N:0]       add_s;
  logic [N:0]       sub_s;
  logic [N-1:0]     s_res;
  logic             s_c;
  logic             s_v;
  logic [N-1:0]     res_q;
  logic [3:0]       flags_q;
  logic [N-1:0]     acc_q;
  logic [N-1:0]     acc_nx;
  logic [N-1:0]     mcand_q;
  logic [N-1:0]     mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic             div_fin;
  logic [N-1:0]     div_res;

  function automatic logic [3:0] mkflg(
    input logic [N-1:0] r,
    input logic         c,
    input logic         v
  );
    logic [3:0] f;
    f        = '0;
    f[FLG_N] = r[N-1];
    f[FLG_Z] = (r == '0);
    f[FLG_C] = c;
    f[FLG_V] = v;
    return f;
  endfunction

  assign op        = alu_op_e'(ALUControl);
  assign accept    = in_valid && (state_q == IDLE);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign flags     = flags_q;
  assign zero      = flags_q[FLG_Z];

  assign add_s  = {1'b0, a} + {1'b0, b};
  assign sub_s  = {1'b0, a} + {1'b0, ~b} + (N + 1)'(1);
  assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef ALU_DIV_EN
  alu_op_e      op_q;
  logic         div0_q;
  logic         s_d0;
  logic         div_go;
  logic [N-1:0] quo;
  logic [N-1:0] rem;

  assign is_div = (op == OP_UDIV) || (op == OP_UREM);
  assign s_d0   = is_div && (b == '0);
  assign div_go = accept && (state_d == DIV);
  assign div0   = div0_q;

  iter_divider #(.N(N)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_go),
    .dividend  (a),
    .divisor   (b),
    .done      (div_fin),
    .quotient  (quo),
    .remainder (rem)
  );

  assign div_res = (op_q == OP_UDIV) ? quo : rem;
`else
  assign is_div  = 1'b0;
  assign div_fin = 1'b1;
  assign div_res = '0;
`endif

  // single-cycle results; anything unlisted is illegal and yields all ones
  always_comb begin
    s_res = '1;
    s_c   = 1'b0;
    s_v   = 1'b0;
    unique case (1'b1)
      (op == OP_AND):   s_res = a & b;
      (op == OP_ORR):   s_res = a | b;
      (op == OP_ADD): begin
        s_res = add_s[N-1:0];
        s_c   = add_s[N];
        s_v   = (a[N-1] == b[N-1]) && (add_s[N-1] != a[N-1]);
      end
      (op == OP_SUB): begin
        s_res = sub_s[N-1:0];
        s_c   = sub_s[N];
        s_v   = (a[N-1] != b[N-1]) && (sub_s[N-1] != a[N-1]);
      end
      (op == OP_PASSB): s_res = b;
`ifdef ALU_DIV_EN
      (op == OP_UDIV):  s_res = '0;
      (op == OP_UREM):  s_res = a;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL)
            state_d = MUL;
          else if (is_div && (b != '0))
            state_d = DIV;
          else
            state_d = DONE;
        end
      end
      MUL:  if (cnt_q == LAST) state_d = DONE;
      DIV:  if (div_fin) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_q    <= '0;
      flags_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`ifdef ALU_DIV_EN
      op_q     <= OP_AND;
      div0_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            acc_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
            cnt_q    <= '0;
`ifdef ALU_DIV_EN
            op_q     <= op;
            div0_q   <= s_d0;
`endif
            if (state_d == DONE) begin
              res_q   <= s_res;
              flags_q <= mkflg(s_res, s_c, s_v);
            end
          end
        end
        MUL: begin
          acc_q    <= acc_nx;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            res_q   <= acc_nx;
            flags_q <= mkflg(acc_nx, 1'b0, 1'b0);
          end
        end
        DIV: begin
          if (div_fin) begin
            res_q   <= div_res;
            flags_q <= mkflg(div_res, 1'b0, 1'b0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
